// File: rtl/seq_alu.sv
// Sequential ALU: 1-cycle arithmetic/logic ops, iterative 1-bit-per-cycle shift/rotate (N+1 cycles for count N).
// Valid/ready on both sides: one operation in flight, result held in HOLD until OutReady, InReady only in IDLE.
module seq_alu #(
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         InValid,
    output logic         InReady,
    input  logic [3:0]   OpCode,
    input  logic [W-1:0] InA,
    input  logic [W-1:0] InB,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [W-1:0] Result,
    output logic         Zero,
    output logic         Carry,
    output logic         Illegal
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_ROL = 4'b0100;
    localparam logic [3:0] OP_ROR = 4'b0101;
    localparam logic [3:0] OP_LSH = 4'b0110;
    localparam logic [3:0] OP_RSH = 4'b0111;
    localparam logic [3:0] OP_MOV = 4'b1111;

    state_t        state_q, state_d;
    logic [1:0]    shop_q;
    logic [W-1:0]  acc_q;
    logic [SW-1:0] cnt_q;
    logic [W-1:0]  result_q;
    logic          zero_q, carry_q, illegal_q;

    logic [SW-1:0] cnt_in;
    logic          is_shift, go_shift, last_step;
    logic [W:0]    sum;
    logic [W-1:0]  alu_res;
    logic          alu_carry, alu_illegal;
    logic [W-1:0]  step_val;
    logic          step_out;

    assign cnt_in    = InB[SW-1:0];
    assign is_shift  = (OpCode[3:2] == 2'b01);
    assign go_shift  = is_shift && (cnt_in != '0);
    assign last_step = (cnt_q == SW'(1));

    always_ff @(posedge Clk) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (InValid) state_d = go_shift ? S_SHIFT : S_HOLD;
            S_SHIFT: if (last_step) state_d = S_HOLD;
            S_HOLD:  if (OutReady) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        InReady  = (state_q == S_IDLE);
        OutValid = (state_q == S_HOLD);
    end

    always_comb begin
        sum         = {1'b0, InA} + {1'b0, InB};
        alu_res     = '0;
        alu_carry   = 1'b0;
        alu_illegal = 1'b0;
        case (OpCode)
            OP_ADD: begin
                alu_res   = sum[W-1:0];
                alu_carry = sum[W];
            end
            OP_SUB: begin
                alu_res   = InA - InB;
                alu_carry = (InA >= InB);
            end
            OP_AND: alu_res = InA & InB;
            OP_XOR: alu_res = InA ^ InB;
            OP_MOV: alu_res = InA;
            // Only reached with a zero shift count: pass InA through.
            OP_ROL, OP_ROR, OP_LSH, OP_RSH: alu_res = InA;
            default: alu_illegal = 1'b1;
        endcase
    end

    // shop_q[0]: 0=left 1=right; shop_q[1]: 0=rotate 1=zero-fill
    always_comb begin
        if (!shop_q[0]) begin
            step_out = acc_q[W-1];
            step_val = {acc_q[W-2:0], shop_q[1] ? 1'b0 : acc_q[W-1]};
        end else begin
            step_out = acc_q[0];
            step_val = {shop_q[1] ? 1'b0 : acc_q[0], acc_q[W-1:1]};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            shop_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (InValid) begin
                    shop_q <= OpCode[1:0];
                    acc_q  <= InA;
                    cnt_q  <= cnt_in;
                    if (!go_shift) begin
                        result_q  <= alu_res;
                        zero_q    <= (alu_res == '0);
                        carry_q   <= alu_carry;
                        illegal_q <= alu_illegal;
                    end
                end
                S_SHIFT: begin
                    acc_q <= step_val;
                    cnt_q <= cnt_q - SW'(1);
                    if (last_step) begin
                        result_q  <= step_val;
                        zero_q    <= (step_val == '0);
                        carry_q   <= step_out;
                        illegal_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Result  = result_q;
    assign Zero    = zero_q;
    assign Carry   = carry_q;
    assign Illegal = illegal_q;

endmodule
